// File: rtl/tone_buzzer_driver_if.sv
// Note-key input and tone outputs of one buzzer channel.
// The playback side is the master; the buzzer driver is the slave.
interface tone_buzzer_driver_if;
  logic       en;
  logic [6:0] key;
  logic       buzzer;
  logic       playing;
  logic [6:0] cur_key;
  logic       period_done;

  modport master (
    output en, key,
    input  buzzer, playing, cur_key, period_done
  );

  modport slave (
    input  en, key,
    output buzzer, playing, cur_key, period_done
  );
endinterface

// File: rtl/tone_buzzer_driver.sv
// Square-wave piezo driver: maps an ASCII note key to a pitch and changes or
// stops the tone only at full-period boundaries.
module tone_buzzer_driver #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  tone_buzzer_driver_if.slave  bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  // Half-period in clocks for a frequency given in centihertz, truncated.
  // Computed in 64 bits because CLK_HZ*100 overflows 32 bits at 50 MHz.
  function automatic logic [CNT_W-1:0] half_of(input logic [63:0] f_chz);
    logic [63:0] h;
    h = (64'(CLK_HZ) * 64'd100) / (64'd2 * f_chz);
    return h[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] H_C4 = half_of(64'd26163);
  localparam logic [CNT_W-1:0] H_D4 = half_of(64'd29366);
  localparam logic [CNT_W-1:0] H_E4 = half_of(64'd32963);
  localparam logic [CNT_W-1:0] H_F4 = half_of(64'd34923);
  localparam logic [CNT_W-1:0] H_G4 = half_of(64'd39200);
  localparam logic [CNT_W-1:0] H_A4 = half_of(64'd44000);
  localparam logic [CNT_W-1:0] H_B4 = half_of(64'd49388);
  localparam logic [CNT_W-1:0] H_C5 = half_of(64'd52325);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // A zero half-period marks a silent key.
  function automatic logic [CNT_W-1:0] half_period(input logic [6:0] k);
    case (k)
      7'h61:   return H_C4;
      7'h73:   return H_D4;
      7'h64:   return H_E4;
      7'h66:   return H_F4;
      7'h67:   return H_G4;
      7'h68:   return H_A4;
      7'h6A:   return H_B4;
      7'h6B:   return H_C5;
      default: return '0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buzzer_q, buzzer_d;
  logic [6:0]       cur_key_q, cur_key_d;
  logic [6:0]       key_q;
  logic [CNT_W-1:0] h_new, h_cur;
  logic             boundary;

  assign h_new = half_period(key_q);
  assign h_cur = half_period(cur_key_q);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buzzer_d  = buzzer_q;
    cur_key_d = cur_key_q;
    boundary  = 1'b0;
    case (state_q)
      IDLE: begin
        buzzer_d = 1'b0;
        if (h_new != '0) begin
          state_d   = PLAY;
          buzzer_d  = 1'b1;
          cur_key_d = key_q;
          cnt_d     = h_new - ONE;
        end
      end
      PLAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (buzzer_q) begin
          buzzer_d = 1'b0;
          cnt_d    = h_cur - ONE;
        end else begin
          // End of a full period: the only point where the key is honoured.
          boundary = 1'b1;
          if (h_new != '0) begin
            buzzer_d  = 1'b1;
            cur_key_d = key_q;
            cnt_d     = h_new - ONE;
          end else begin
            state_d   = IDLE;
            cur_key_d = 7'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buzzer_q  <= 1'b0;
      cur_key_q <= 7'd0;
      key_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buzzer_q  <= buzzer_d;
      cur_key_q <= cur_key_d;
      key_q     <= bus.en ? bus.key : 7'd0;
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.playing     = (state_q == PLAY);
  assign bus.cur_key     = cur_key_q;
  assign bus.period_done = boundary;

endmodule

// File: tb/tb_tone_buzzer_driver.sv
// Directed bench for tone_buzzer_driver at CLK_HZ=2_616_300 (C4 half-period
// 5000 clocks, A4 half-period 2973 clocks).
module tb_tone_buzzer_driver;

  localparam int unsigned CLK_HZ = 2_616_300;
  localparam int H_C4 = 5000;
  localparam int H_A4 = 2973;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   len, pd;
  logic quiet;

  tone_buzzer_driver_if bus ();

  tone_buzzer_driver #(.CLK_HZ(CLK_HZ), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clocks while buzzer holds `level` and the note is playing; counts
  // period_done pulses seen in that span. Optionally rewrites key mid-phase.
  task automatic run_phase(input logic level, input int change_at, input logic [6:0] new_key,
                           input int restore_at, input logic [6:0] restore_key,
                           output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (n < 20000) begin
      tick();
      n++;
      if (bus.buzzer !== level || bus.playing !== 1'b1) break;
      if (bus.period_done) pulses++;
      if (n == change_at)  bus.key = new_key;
      if (n == restore_at) bus.key = restore_key;
    end
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.key = 7'd0;

    // Async reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    check("rst_buzzer",  bus.buzzer, 0);
    check("rst_playing", bus.playing, 0);
    check("rst_cur_key", bus.cur_key, 0);
    check("rst_pdone",   bus.period_done, 0);
    #1 rst = 1'b0;

    quiet = 1'b0;
    repeat (100) begin
      tick();
      quiet |= bus.buzzer | bus.playing;
    end
    check("idle_key0_quiet", quiet, 0);

    // Start C4: rise two edges after the key is applied
    bus.en  = 1'b1;
    bus.key = 7'h61;
    tick();
    check("lat_edge1_buzzer", bus.buzzer, 0);
    tick();
    check("lat_edge2_buzzer",  bus.buzzer, 1);
    check("lat_edge2_playing", bus.playing, 1);
    check("lat_edge2_cur_key", bus.cur_key, 32'h61);

    run_phase(1'b1, -1, 7'd0, -1, 7'd0, len, pd);
    check("c4_high1_len", len, H_C4);
    check("c4_high1_pd",  pd, 0);
    run_phase(1'b0, -1, 7'd0, -1, 7'd0, len, pd);
    check("c4_low1_len", len, H_C4);
    check("c4_low1_pd",  pd, 1);
    check("c4_rise2_key", bus.cur_key, 32'h61);

    // Switch to A4 1000 cycles into a high phase: C4 period completes intact
    run_phase(1'b1, 1000, 7'h68, -1, 7'd0, len, pd);
    check("sw_high_len", len, H_C4);
    check("sw_high_key", bus.cur_key, 32'h61);
    run_phase(1'b0, -1, 7'd0, -1, 7'd0, len, pd);
    check("sw_low_len", len, H_C4);
    check("sw_low_pd",  pd, 1);
    check("a4_cur_key", bus.cur_key, 32'h68);
    check("a4_playing", bus.playing, 1);

    run_phase(1'b1, 100, 7'h61, -1, 7'd0, len, pd);
    check("a4_high_len", len, H_A4);
    run_phase(1'b0, -1, 7'd0, -1, 7'd0, len, pd);
    check("a4_low_len", len, H_A4);
    check("back_c4_key", bus.cur_key, 32'h61);

    // Brief release and re-press mid-period: no gap
    run_phase(1'b1, 1000, 7'd0, 1010, 7'h61, len, pd);
    check("pulse_high_len", len, H_C4);
    run_phase(1'b0, -1, 7'd0, -1, 7'd0, len, pd);
    check("pulse_low_len", len, H_C4);
    check("pulse_rise",    bus.buzzer, 1);
    check("pulse_cur_key", bus.cur_key, 32'h61);

    // Release mid high phase: finish the period, then stop
    run_phase(1'b1, 2500, 7'd0, -1, 7'd0, len, pd);
    check("stop_high_len", len, H_C4);
    run_phase(1'b0, -1, 7'd0, -1, 7'd0, len, pd);
    check("stop_low_len", len, H_C4);
    check("stop_low_pd",  pd, 1);
    check("stop_playing", bus.playing, 0);
    check("stop_cur_key", bus.cur_key, 0);
    check("stop_buzzer",  bus.buzzer, 0);
    quiet = 1'b0;
    repeat (100) begin
      tick();
      quiet |= bus.buzzer | bus.playing;
    end
    check("stop_stays_quiet", quiet, 0);

    // Unmapped key and disabled channel both stay silent
    bus.key = 7'h7A;
    quiet = 1'b0;
    repeat (50) begin
      tick();
      quiet |= bus.buzzer | bus.playing;
    end
    check("key_z_quiet", quiet, 0);
    bus.en  = 1'b0;
    bus.key = 7'h61;
    quiet = 1'b0;
    repeat (50) begin
      tick();
      quiet |= bus.buzzer | bus.playing;
    end
    check("en0_quiet", quiet, 0);

    // Async reset mid high phase, between edges
    bus.en = 1'b1;
    tick();
    tick();
    check("restart_buzzer", bus.buzzer, 1);
    repeat (2000) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_buzzer",  bus.buzzer, 0);
    check("midrst_playing", bus.playing, 0);
    check("midrst_cur_key", bus.cur_key, 0);
    #2 rst = 1'b0;
    tick();
    check("postrst_edge1_buzzer", bus.buzzer, 0);
    tick();
    check("postrst_edge2_buzzer",  bus.buzzer, 1);
    check("postrst_edge2_cur_key", bus.cur_key, 32'h61);
    run_phase(1'b1, -1, 7'd0, -1, 7'd0, len, pd);
    check("postrst_high_len", len, H_C4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
